// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the multi-cycle controller and the HI/LO multiply/divide unit.
interface mult_div_unit_if #(
    parameter int unsigned DATA_W = 32
);
    logic              Start;
    logic [2:0]        Op;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic              Busy;
    logic              Done;
    logic              DivZero;
    logic [DATA_W-1:0] HI;
    logic [DATA_W-1:0] LO;

    modport master (
        output Start, Op, A, B,
        input  Busy, Done, DivZero, HI, LO
    );

    modport slave (
        input  Start, Op, A, B,
        output Busy, Done, DivZero, HI, LO
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with sign handling done on magnitudes at the ends.
module mult_div_unit #(
    parameter int unsigned DATA_W = 32
) (
    input  logic            CLK,
    input  logic            RST,
    mult_div_unit_if.slave  bus
);
    localparam int unsigned CntW = $clog2(DATA_W);

    typedef enum logic [1:0] {StIdle, StCalc, StFin} state_t;

    state_t              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]   opnd_q, opnd_d;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic                is_div_q, is_div_d;
    logic                neg_lo_q, neg_lo_d;
    logic                neg_hi_q, neg_hi_d;
    logic                dz_q, dz_d;
    logic                done_q, done_d;
    logic                divzero_q, divzero_d;
    logic                busy;

    logic              arith_start, op_div, op_signed, b_zero;
    logic [DATA_W-1:0] abs_a, abs_b;
    logic [DATA_W:0]   mul_sum, div_shift, div_trial;
    logic [DATA_W-1:0] quo, rem;

    assign arith_start = bus.Start && !bus.Op[2];
    assign op_div      = bus.Op[1];
    assign op_signed   = !bus.Op[0];
    assign b_zero      = (bus.B == '0);
    assign abs_a       = (op_signed && bus.A[DATA_W-1]) ? -bus.A : bus.A;
    assign abs_b       = (op_signed && bus.B[DATA_W-1]) ? -bus.B : bus.B;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    assign mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, opnd_q};
    assign div_shift = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    assign div_trial = div_shift - {1'b0, opnd_q};
    assign quo       = acc_q[DATA_W-1:0];
    assign rem       = acc_q[2*DATA_W-1:DATA_W];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (arith_start) begin
                    state_d = (op_div && b_zero) ? StFin : StCalc;
                end
            end
            StCalc: begin
                if (cnt_q == CntW'(DATA_W - 1)) begin
                    state_d = StFin;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = (state_q != StIdle);
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_lo_d  = neg_lo_q;
        neg_hi_d  = neg_hi_q;
        dz_d      = dz_q;
        done_d    = 1'b0;
        divzero_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (arith_start) begin
                    is_div_d = op_div;
                    neg_lo_d = op_signed && (bus.A[DATA_W-1] ^ bus.B[DATA_W-1]);
                    neg_hi_d = op_signed && bus.A[DATA_W-1];
                    dz_d     = op_div && b_zero;
                    cnt_d    = '0;
                    if (op_div) begin
                        opnd_d = abs_b;
                        acc_d  = {{DATA_W{1'b0}}, abs_a};
                    end else begin
                        opnd_d = abs_a;
                        acc_d  = {{DATA_W{1'b0}}, abs_b};
                    end
                end else if (bus.Start && bus.Op == 3'd4) begin
                    hi_d = bus.A;
                end else if (bus.Start && bus.Op == 3'd5) begin
                    lo_d = bus.A;
                end
            end
            StCalc: begin
                cnt_d = cnt_q + 1'b1;
                if (is_div_q) begin
                    if (!div_trial[DATA_W]) begin
                        acc_d = {div_trial[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
                    end else begin
                        acc_d = {div_shift[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
                    end
                end else if (acc_q[0]) begin
                    acc_d = {mul_sum, acc_q[DATA_W-1:1]};
                end else begin
                    acc_d = {1'b0, acc_q[2*DATA_W-1:1]};
                end
            end
            StFin: begin
                done_d    = 1'b1;
                divzero_d = dz_q;
                cnt_d     = '0;
                if (!dz_q) begin
                    if (is_div_q) begin
                        lo_d = neg_lo_q ? -quo : quo;
                        hi_d = neg_hi_q ? -rem : rem;
                    end else begin
                        {hi_d, lo_d} = neg_lo_q ? -acc_q : acc_q;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_lo_q  <= neg_lo_d;
            neg_hi_q  <= neg_hi_d;
            dz_q      <= dz_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
        end
    end

    assign bus.Busy    = busy;
    assign bus.Done    = done_q;
    assign bus.DivZero = divzero_q;
    assign bus.HI      = hi_q;
    assign bus.LO      = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized ops against an arithmetic model.
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [31:0] hi_m = '0, lo_m = '0;

    mult_div_unit_if #(.DATA_W(32)) bus ();

    mult_div_unit #(.DATA_W(32)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, b,
                                          input logic [31:0] hi, lo);
        longint      sa, sb;
        logic [63:0] q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: model = sa * sb;
            3'd1: model = {32'b0, a} * {32'b0, b};
            3'd2: begin
                if (b == 0) model = {hi, lo};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    model = {r[31:0], q[31:0]};
                end
            end
            3'd3: model = (b == 0) ? {hi, lo} : {a % b, a / b};
            3'd4: model = {a, lo};
            3'd5: model = {hi, a};
            default: model = {hi, lo};
        endcase
    endfunction

    // Called at a negedge; returns at the negedge where Done is seen (or after the bound).
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, b,
                         input int pest_from, input int pest_to,
                         output int busy_n, output int done_at, output logic dz);
        bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b;
        @(negedge clk);
        bus.Start = 1'b0;
        busy_n = 0; done_at = -1; dz = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            if (bus.Done) begin
                done_at = i;
                dz = bus.DivZero;
                break;
            end
            if (bus.Busy) busy_n++;
            if (i >= pest_from && i <= pest_to) begin
                bus.Start = 1'b1; bus.Op = 3'd2; bus.A = $urandom; bus.B = $urandom;
            end else begin
                bus.Start = 1'b0;
            end
            @(negedge clk);
        end
        bus.Start = 1'b0;
    endtask

    task automatic run_arith(input string tag, input logic [2:0] op, input logic [31:0] a, b);
        int busy_n, done_at;
        logic dz;
        logic [63:0] exp;
        bit zero;
        zero = (op[1] && b == 0);
        exp = model(op, a, b, hi_m, lo_m);
        do_op(op, a, b, 0, -1, busy_n, done_at, dz);
        check({tag, "_busy"}, busy_n, zero ? 1 : 33);
        check({tag, "_done_at"}, done_at, zero ? 2 : 34);
        check({tag, "_divzero"}, dz, zero);
        check({tag, "_hilo"}, {bus.HI, bus.LO}, exp);
        hi_m = exp[63:32]; lo_m = exp[31:0];
    endtask

    task automatic run_move(input logic [2:0] op, input logic [31:0] a);
        logic [63:0] exp;
        exp = model(op, a, 32'h0, hi_m, lo_m);
        bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = $urandom;
        @(negedge clk);
        bus.Start = 1'b0;
        check("move_busy", bus.Busy, 1'b0);
        check("move_hilo", {bus.HI, bus.LO}, exp);
        @(negedge clk);
        check("move_done", bus.Done, 1'b0);
        hi_m = exp[63:32]; lo_m = exp[31:0];
    endtask

    initial begin
        int busy_n, done_at, cnt;
        logic dz;
        logic [2:0] op;
        logic [31:0] a, b;
        bus.Start = 1'b0; bus.Op = '0; bus.A = '0; bus.B = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", bus.Busy, 1'b0);
        check("rst_done", {bus.Done, bus.DivZero}, 2'b00);
        check("rst_hilo", {bus.HI, bus.LO}, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        // Multiply latency and results
        do_op(3'd0, 32'hFFFFFFFD, 32'd5, 0, -1, busy_n, done_at, dz);
        check("mult_busy", busy_n, 33);
        check("mult_done_at", done_at, 34);
        check("mult_hilo", {bus.HI, bus.LO}, 64'hFFFFFFFF_FFFFFFF1);
        @(negedge clk);
        check("mult_done_pulse", {bus.Done, bus.Busy}, 2'b00);
        do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, -1, busy_n, done_at, dz);
        check("multu_hilo", {bus.HI, bus.LO}, 64'hFFFFFFFE_00000001);
        @(negedge clk);

        // Divide results
        do_op(3'd2, 32'hFFFFFFF9, 32'd2, 0, -1, busy_n, done_at, dz);
        check("div_neg_hilo", {bus.HI, bus.LO}, 64'hFFFFFFFF_FFFFFFFD);
        check("div_done_at", done_at, 34);
        @(negedge clk);
        do_op(3'd3, 32'd100, 32'd7, 0, -1, busy_n, done_at, dz);
        check("divu_hilo", {bus.HI, bus.LO}, 64'h00000002_0000000E);
        @(negedge clk);
        do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, -1, busy_n, done_at, dz);
        check("div_ovf_hilo", {bus.HI, bus.LO}, 64'h00000000_80000000);
        @(negedge clk);

        // Divide by zero with preloaded HI/LO
        hi_m = bus.HI; lo_m = bus.LO;
        run_move(3'd4, 32'h11);
        run_move(3'd5, 32'h22);
        do_op(3'd2, 32'h1234, 32'h0, 0, -1, busy_n, done_at, dz);
        check("dz_busy", busy_n, 1);
        check("dz_done_at", done_at, 2);
        check("dz_flag", dz, 1'b1);
        check("dz_hilo", {bus.HI, bus.LO}, 64'h00000011_00000022);
        @(negedge clk);
        check("dz_clear", {bus.Done, bus.DivZero}, 2'b00);

        // Start while busy is ignored
        do_op(3'd1, 32'd3, 32'd4, 5, 10, busy_n, done_at, dz);
        check("pester_done_at", done_at, 34);
        check("pester_hilo", {bus.HI, bus.LO}, 64'd12);
        @(negedge clk);
        check("pester_idle", {bus.Busy, bus.Done}, 2'b00);

        // Asynchronous reset mid-operation
        bus.Start = 1'b1; bus.Op = 3'd0; bus.A = 32'h1234567; bus.B = 32'h89;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy_done", {bus.Busy, bus.Done}, 2'b00);
        check("arst_hilo", {bus.HI, bus.LO}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.Done || bus.Busy) cnt++;
        end
        check("arst_no_done", cnt, 0);
        hi_m = '0; lo_m = '0;
        do_op(3'd1, 32'd2, 32'd3, 0, -1, busy_n, done_at, dz);
        check("arst_after_hilo", {bus.HI, bus.LO}, 64'd6);

        // Back-to-back: start during the Done cycle
        do_op(3'd1, 32'd6, 32'd7, 0, -1, busy_n, done_at, dz);
        check("b2b_done_at", done_at, 34);
        check("b2b_hilo", {bus.HI, bus.LO}, 64'd42);
        hi_m = bus.HI; lo_m = bus.LO;
        @(negedge clk);

        // Randomized ops against the model
        for (int k = 0; k < 30; k++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) b = '0;
            if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
            if (op < 3'd4) begin
                run_arith("rand", op, a, b);
                if ($urandom_range(0, 1) == 0) @(negedge clk);
            end else begin
                run_move(op, a);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative HI/LO multiply/divide unit for the multi-cycle MIPS datapath.
- Sits directly downstream of the A/B operand latch: its operands are the latched ResultA/ResultB values. It serves the MULT/MULTU/DIV/DIVU/MTHI/MTLO instructions.
- Controller pulses Start, stalls on Busy, and reads HI/LO (for MFHI/MFLO) once Done is seen.
- Shift-add multiply and restoring divide, one bit per cycle.

Parameters:
- DATA_W, 32, operand/HI/LO width; iteration count equals DATA_W.

Ports:
- CLK, input, 1, system clock, rising-edge.
- RST, input, 1, asynchronous active-high reset.
- Start, input, 1, request; sampled on a CLK rising edge.
- Op, input, 3, operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op.
- A, input, DATA_W, operand A (multiplicand/dividend/MTHI-MTLO source), from the A/B latch.
- B, input, DATA_W, operand B (multiplier/divisor), from the A/B latch.
- Busy, output, 1, high while a multiply/divide is in progress.
- Done, output, 1, one-cycle completion pulse.
- DivZero, output, 1, high with Done when a divide had B==0.
- HI, output, DATA_W, HI register.
- LO, output, DATA_W, LO register.

Behaviour:
- Reset: one clock (CLK); reset is asynchronous and active-high (RST).
  - RST=1 immediately forces state IDLE, HI=0, LO=0, Busy=0, Done=0, DivZero=0, counter=0.
  - This applies mid-operation; an aborted op leaves no result.
- States: IDLE, CALC, FIN.
- IDLE:
  - Start=1 with Op 0-3 at edge E0: latch Op, A, B internally; later changes on A/B are ignored.
  - Signed ops (0, 2) latch magnitudes plus sign bits. Go to CALC with counter=0, Busy=1.
  - Exception: DIV/DIVU with B==0 goes to FIN directly.
  - Op 4 (MTHI) writes HI=A; Op 5 (MTLO) writes LO=A. Both take effect at the Start edge, with no Busy and no Done.
  - Op 6/7 is ignored.
- CALC: one iteration per edge, E1..E32.
  - Multiply: 64-bit shift-add accumulator.
  - Divide: restoring shift-subtract.
  - At the edge where counter==DATA_W-1, go to FIN.
- FIN (next edge, E33):
  - Apply sign fixes and write HI/LO.
  - Busy=0; Done=1 for exactly one cycle; return to IDLE.
- Latency:
  - Normal multiply/divide: Busy=1 from after E0 to after E33; Done=1 for the cycle after E33.
  - Divide by zero: Busy=1 for one cycle; Done=1 and DivZero=1 for the cycle after E1; HI/LO unchanged.
- Start while Busy=1 is ignored: no latch, no state change. Start during the Done cycle is accepted (state is IDLE).
- Arithmetic rules:
  - MULT: {HI,LO} = signed 64-bit product; negate the magnitude product if the sign bits differ.
  - MULTU: unsigned 64-bit product.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wraps, no trap).
  - DIVU: unsigned quotient in LO, remainder in HI.
- DivZero is cleared on the cycle after its Done pulse. Done and DivZero are never high outside the Done cycle.
- HI/LO hold their values except at FIN writes, MTHI/MTLO, and reset.

Test Plan:
- Multiply latency and results: reset, then MULT with A=0xFFFFFFFD, B=5.
  - Busy high 33 cycles; Done pulse after E33.
  - HI=0xFFFFFFFF, LO=0xFFFFFFF1.
  - Then MULTU with A=B=0xFFFFFFFF gives HI=0xFFFFFFFE, LO=0x00000001.
- Divide results:
  - DIV A=0xFFFFFFF9 (-7), B=2 gives LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU A=100, B=7 gives LO=0x0000000E, HI=0x00000002.
  - DIV A=0x80000000, B=0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero: HI=0x11, LO=0x22 preloaded via MTHI/MTLO, then DIV with B=0.
  - Done=1 and DivZero=1 one cycle after E1; HI=0x11, LO=0x22 unchanged.
- Start while busy: MULTU 3*4 started, then Start with Op=DIV asserted on cycles 5-10 and A/B changed.
  - Second Start ignored; result is HI=0, LO=12 at E33.
- Reset mid-op: RST pulsed asynchronously (between edges) at cycle 10 of a MULT.
  - Busy, Done, HI, LO read 0 immediately; no Done later.
  - A following MULTU 2*3 gives LO=6.
- Back-to-back: Start MULTU 6*7 during the Done cycle of a prior op.
  - Accepted; LO=42 after 33 further cycles.
